// File: rtl/iobuf_turnaround_ctrl_pkg.sv
// Shared types and constants for the bidirectional pad-bus turnaround controller.
// The turn counter is 4 bits wide, which covers a programmable turnaround of up to 15 cycles.
package iobuf_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IN   = 3'd0,
        ST_T2O  = 3'd1,
        ST_OUT  = 3'd2,
        ST_T2I  = 3'd3,
        ST_SYNC = 3'd4
    } state_e;

    typedef enum logic {
        TARGET_INFERRED = 1'b0,
        TARGET_KC705    = 1'b1
    } target_e;

    localparam int CNT_W = $clog2(16);

    localparam state_e           STATE_RST   = ST_IN;
    localparam logic [CNT_W-1:0] CNT_RST     = '0;
    localparam logic [CNT_W-1:0] SYNC_CYCLES = CNT_W'(2);

endpackage

// File: rtl/iobuf_turnaround_ctrl_if.sv
// Request / read-back handshake between a bus peripheral and the pad turnaround controller.
interface iobuf_turnaround_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             i_req_valid;
    logic             i_req_dir;
    logic [WIDTH-1:0] i_req_data;
    logic             o_req_ready;
    logic             o_rd_valid;
    logic [WIDTH-1:0] o_rd_data;
    logic             o_drv_active;

    modport master (
        output i_req_valid, i_req_dir, i_req_data,
        input  o_req_ready, o_rd_valid, o_rd_data, o_drv_active
    );

    modport slave (
        input  i_req_valid, i_req_dir, i_req_data,
        output o_req_ready, o_rd_valid, o_rd_data, o_drv_active
    );
endinterface

// File: rtl/iobuf_turnaround_ctrl_tech.sv
// One-bit technology bidirectional buffer: t=1 releases the pad, o always returns the pad value.
module iobuf_tech
    import iobuf_ctrl_pkg::*;
#(
    parameter target_e TARGET = TARGET_INFERRED
) (
    output logic o,
    inout  wire  io,
    input  logic i,
    input  logic t
);

    generate
        if (TARGET == TARGET_KC705) begin : g_kc705
`ifdef IOBUF_USE_UNISIM
            IOBUF u_iobuf (.O(o), .IO(io), .I(i), .T(t));
`else
            // Without the vendor library compiled in, fall back to an inferred tristate.
            assign io = t ? 1'bz : i;
            assign o  = io;
`endif
        end else begin : g_inferred
            assign io = t ? 1'bz : i;
            assign o  = io;
        end
    endgenerate

endmodule

// File: rtl/iobuf_turnaround_ctrl.sv
// Sequenced driver for a bidirectional pad bus. It inserts high-Z turnaround cycles on every
// direction change and samples the pads through a two-flop synchroniser.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_IN   | pads released, reads serviced in one cycle
//  ST_T2O  | pads released, counting down before the bus is driven
//  ST_OUT  | pads driven from the data register
//  ST_T2I  | pads released, counting down before the pads are sampled
//  ST_SYNC | synchroniser flush, then the read result is returned
module iobuf_turnaround_ctrl
    import iobuf_ctrl_pkg::*;
#(
    parameter int      WIDTH       = 8,
    parameter int      TURN_CYCLES = 2,
    parameter target_e TARGET      = TARGET_INFERRED
) (
    input  logic                    i_clk,
    input  logic                    i_nrst,
    iobuf_turnaround_ctrl_if.slave  bus,
    inout  wire [WIDTH-1:0]         io_pad
);

    localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               drv_q;
    logic [WIDTH-1:0]   sync1_q, sync2_q;
    logic [WIDTH-1:0]   pad_in;
    logic               pad_t;
    logic               ready;
    logic               accept;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= STATE_RST;
            cnt_q      <= CNT_RST;
            data_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            drv_q      <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            // Registered from the next state so the enable can never glitch.
            drv_q      <= (state_d == ST_OUT);
            sync1_q    <= pad_in;
            sync2_q    <= sync1_q;
        end
    end

    assign accept = bus.i_req_valid & ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        case (state_q)
            ST_IN: begin
                if (accept) begin
                    if (bus.i_req_dir) begin
                        data_d  = bus.i_req_data;
                        cnt_d   = TURN_LD;
                        state_d = ST_T2O;
                    end else begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = sync2_q;
                    end
                end
            end
            ST_T2O: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) state_d = ST_OUT;
            end
            ST_OUT: begin
                if (accept) begin
                    if (bus.i_req_dir) begin
                        data_d = bus.i_req_data;
                    end else begin
                        cnt_d   = TURN_LD;
                        state_d = ST_T2I;
                    end
                end
            end
            ST_T2I: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    cnt_d   = SYNC_CYCLES;
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = sync2_q;
                    state_d    = ST_IN;
                end
            end
            default: begin
                cnt_d   = CNT_RST;
                state_d = ST_IN;
            end
        endcase
    end

    always_comb begin
        ready = (state_q == ST_IN) || (state_q == ST_OUT);
    end

    assign pad_t            = ~drv_q;
    assign bus.o_req_ready  = ready;
    assign bus.o_rd_valid   = rd_valid_q;
    assign bus.o_rd_data    = rd_data_q;
    assign bus.o_drv_active = drv_q;

    for (genvar g = 0; g < WIDTH; g++) begin : g_pad
        iobuf_tech #(.TARGET(TARGET)) u_buf (
            .o  (pad_in[g]),
            .io (io_pad[g]),
            .i  (data_q[g]),
            .t  (pad_t)
        );
    end

endmodule

// File: tb/tb_iobuf_turnaround_ctrl.sv
// Directed bench for the pad turnaround controller: a per-cycle vector table, plus short
// sequences for async reset and for a single-cycle turnaround instance.
module tb_iobuf_turnaround_ctrl;
    import iobuf_ctrl_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iobuf_turnaround_ctrl_if #(.WIDTH(W)) bus0 ();
    iobuf_turnaround_ctrl_if #(.WIDTH(W)) bus1 ();

    wire  [W-1:0] pad0;
    wire  [W-1:0] pad1;
    logic         ext0_en = 1'b0;
    logic [W-1:0] ext0_val = '0;
    logic         ext1_en = 1'b0;
    logic [W-1:0] ext1_val = '0;

    assign pad0 = ext0_en ? ext0_val : 'z;
    assign pad1 = ext1_en ? ext1_val : 'z;

    iobuf_turnaround_ctrl #(.WIDTH(W), .TURN_CYCLES(2)) dut (
        .i_clk  (clk),
        .i_nrst (rst_n),
        .bus    (bus0.slave),
        .io_pad (pad0)
    );

    iobuf_turnaround_ctrl #(.WIDTH(W), .TURN_CYCLES(1)) dut1 (
        .i_clk  (clk),
        .i_nrst (rst_n),
        .bus    (bus1.slave),
        .io_pad (pad1)
    );

    typedef struct packed {
        logic         v;
        logic         d;
        logic [W-1:0] data;
        logic         xe;
        logic [W-1:0] xv;
        logic         e_rdy;
        logic         e_rdv;
        logic         e_drv;
        logic [W-1:0] e_dat;
    } vec_t;

    localparam int NV = 24;
    vec_t vt[NV];

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        // v d data xe xv | rdy rdv drv dat(rd_data if rdv, pad if drv)
        vt[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[3]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5A};
        vt[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[6]  = '{1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C};
        vt[7]  = '{1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11};
        vt[8]  = '{1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22};
        vt[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33};
        vt[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[14] = '{1'b1, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hC3};
        vt[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h77};
        vt[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[21] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[22] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h96, 1'b1, 1'b1, 1'b0, 8'h96};
        vt[23] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};

        bus0.i_req_valid = 1'b0;
        bus0.i_req_dir   = 1'b0;
        bus0.i_req_data  = '0;
        bus1.i_req_valid = 1'b0;
        bus1.i_req_dir   = 1'b0;
        bus1.i_req_data  = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_rd_valid", 32'(bus0.o_rd_valid), 32'h0);
        chk("rst_rd_data", 32'(bus0.o_rd_data), 32'h0);
        chk("rst_drv", 32'(bus0.o_drv_active), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            bus0.i_req_valid = vt[i].v;
            bus0.i_req_dir   = vt[i].d;
            bus0.i_req_data  = vt[i].data;
            ext0_en          = vt[i].xe;
            ext0_val         = vt[i].xv;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(bus0.o_req_ready), 32'(vt[i].e_rdy));
            chk($sformatf("vec%0d_rd_valid", i), 32'(bus0.o_rd_valid), 32'(vt[i].e_rdv));
            chk($sformatf("vec%0d_drv", i), 32'(bus0.o_drv_active), 32'(vt[i].e_drv));
            if (vt[i].e_rdv)
                chk($sformatf("vec%0d_rd_data", i), 32'(bus0.o_rd_data), 32'(vt[i].e_dat));
            if (vt[i].e_drv)
                chk($sformatf("vec%0d_pad", i), 32'(pad0), 32'(vt[i].e_dat));
            @(negedge clk);
        end

        // Async reset while driving 0xA5: pads must release without waiting for a clock.
        bus0.i_req_valid = 1'b1;
        bus0.i_req_dir   = 1'b1;
        bus0.i_req_data  = 8'hA5;
        ext0_en          = 1'b0;
        @(negedge clk);
        bus0.i_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("pre_rst_drv", 32'(bus0.o_drv_active), 32'h1);
        chk("pre_rst_pad", 32'(pad0), 32'hA5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_drv", 32'(bus0.o_drv_active), 32'h0);
        chk("async_rst_rd_valid", 32'(bus0.o_rd_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus0.o_req_ready), 32'h1);
        chk("post_rst_drv", 32'(bus0.o_drv_active), 32'h0);

        // Reset in the middle of a turnaround drops the pending write.
        bus0.i_req_valid = 1'b1;
        bus0.i_req_dir   = 1'b1;
        bus0.i_req_data  = 8'h5F;
        @(negedge clk);
        bus0.i_req_valid = 1'b0;
        #1;
        chk("t2o_ready", 32'(bus0.o_req_ready), 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("dropped_drv%0d", k), 32'(bus0.o_drv_active), 32'h0);
            chk($sformatf("dropped_ready%0d", k), 32'(bus0.o_req_ready), 32'h1);
            @(negedge clk);
        end

        // Single-cycle turnaround instance: 1 high-Z cycle, read latency of 4 cycles.
        bus1.i_req_valid = 1'b1;
        bus1.i_req_dir   = 1'b1;
        bus1.i_req_data  = 8'h5C;
        #1;
        chk("tc1_ready_in", 32'(bus1.o_req_ready), 32'h1);
        @(negedge clk);
        bus1.i_req_valid = 1'b0;
        #1;
        chk("tc1_t2o_drv", 32'(bus1.o_drv_active), 32'h0);
        chk("tc1_t2o_ready", 32'(bus1.o_req_ready), 32'h0);
        @(negedge clk);
        bus1.i_req_valid = 1'b1;
        bus1.i_req_dir   = 1'b0;
        #1;
        chk("tc1_out_drv", 32'(bus1.o_drv_active), 32'h1);
        chk("tc1_out_pad", 32'(pad1), 32'h5C);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus1.i_req_valid = 1'b0;
            ext1_en          = 1'b1;
            ext1_val         = 8'hE1;
            #1;
            chk($sformatf("tc1_rd_valid%0d", k), 32'(bus1.o_rd_valid), (k == 4) ? 32'h1 : 32'h0);
            if (k == 1)
                chk("tc1_released", 32'(bus1.o_drv_active), 32'h0);
        end
        chk("tc1_rd_data", 32'(bus1.o_rd_data), 32'hE1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
